// File: rtl/character_ctrl.sv
//------------------------------------------------------------------------------
// Module  : character_ctrl
// Brief   : Frame-rate sprite controller: walk, jump/gravity and kick timing.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module character_ctrl #(
    parameter logic [7:0] LEFT_KEY      = 8'h04,
    parameter logic [7:0] RIGHT_KEY     = 8'h07,
    parameter logic [7:0] JUMP_KEY      = 8'h1A,
    parameter logic [7:0] KICK_KEY      = 8'h16,
    parameter int         X_START       = 200,
    parameter int         X_MIN         = 0,
    parameter int         X_MAX         = 639,
    parameter int         GROUND_Y      = 400,
    parameter int         SIZE          = 32,
    parameter int         WALK_SPEED    = 4,
    parameter int         JUMP_VEL      = 18,
    parameter int         GRAVITY       = 1,
    parameter int         MAX_FALL      = 12,
    parameter int         KICK_FRAMES   = 6,
    parameter int         KICK_COOLDOWN = 10
) (
    input  logic        frame_clk,
    input  logic        Reset_n,
    input  logic        enable,
    input  logic [31:0] keycode,
    output logic [9:0]  CharX,
    output logic [9:0]  CharY,
    output logic [9:0]  CharS,
    output logic        Facing,
    output logic        Kicking,
    output logic        Airborne
);

    localparam logic signed [11:0] c_x_lo      = 12'(X_MIN);
    localparam logic signed [11:0] c_x_hi      = 12'(X_MAX - SIZE);
    localparam logic signed [11:0] c_ground    = 12'(GROUND_Y - SIZE);
    localparam logic signed [11:0] c_walk      = 12'(WALK_SPEED);
    localparam logic signed [10:0] c_jump_vel  = 11'(JUMP_VEL);
    localparam logic signed [10:0] c_gravity   = 11'(GRAVITY);
    localparam logic signed [10:0] c_max_fall  = 11'(MAX_FALL);
    localparam logic [7:0]         c_kick_load = 8'(KICK_FRAMES - 1);
    localparam logic [7:0]         c_cool_load = 8'(KICK_COOLDOWN - 1);

    typedef enum logic [0:0] {
        GROUND = 1'b0,
        AIR    = 1'b1
    } motion_t;

    typedef enum logic [1:0] {
        K_IDLE   = 2'd0,
        K_ACTIVE = 2'd1,
        K_COOL   = 2'd2
    } kick_t;

    logic [9:0]         x_q, x_d;
    logic [9:0]         y_q, y_d;
    logic signed [10:0] vy_q, vy_d;
    logic               facing_q, facing_d;
    motion_t            mstate_q, mstate_d;
    kick_t              kstate_q, kstate_d;
    logic [7:0]         kcnt_q, kcnt_d;
    logic               jump_prev_q, jump_prev_d;
    logic               kick_prev_q, kick_prev_d;

    logic               w_left, w_right, w_jump, w_kick;
    logic               w_jump_edge, w_kick_edge;
    logic signed [11:0] w_dx, w_x_sum, w_y_sum;
    logic signed [10:0] w_vy_new;
    logic               w_apply_vy;

    // A zero code in a parameter must never match an empty key slot.
    function automatic logic key_match(input logic [31:0] kc, input logic [7:0] code);
        return (code != 8'h00) &&
               ((kc[31:24] == code) || (kc[23:16] == code) ||
                (kc[15:8]  == code) || (kc[7:0]   == code));
    endfunction

    assign w_left      = key_match(keycode, LEFT_KEY);
    assign w_right     = key_match(keycode, RIGHT_KEY);
    assign w_jump      = key_match(keycode, JUMP_KEY);
    assign w_kick      = key_match(keycode, KICK_KEY);
    assign w_jump_edge = w_jump & ~jump_prev_q;
    assign w_kick_edge = w_kick & ~kick_prev_q;
    assign jump_prev_d = w_jump;
    assign kick_prev_d = w_kick;

    always_comb begin
        w_dx     = '0;
        facing_d = facing_q;
        if (w_left && !w_right) begin
            w_dx     = -c_walk;
            facing_d = 1'b0;
        end else if (w_right && !w_left) begin
            w_dx     = c_walk;
            facing_d = 1'b1;
        end
        w_x_sum = $signed({2'b00, x_q}) + w_dx;
        if (w_x_sum < c_x_lo) begin
            x_d = c_x_lo[9:0];
        end else if (w_x_sum > c_x_hi) begin
            x_d = c_x_hi[9:0];
        end else begin
            x_d = w_x_sum[9:0];
        end
    end

    always_comb begin
        mstate_d   = mstate_q;
        vy_d       = vy_q;
        y_d        = y_q;
        w_vy_new   = vy_q;
        w_apply_vy = 1'b0;
        case (mstate_q)
            GROUND: begin
                if (w_jump_edge) begin
                    w_vy_new   = -c_jump_vel;
                    w_apply_vy = 1'b1;
                    mstate_d   = AIR;
                end
            end
            AIR: begin
                w_vy_new = vy_q + c_gravity;
                if (w_vy_new > c_max_fall) begin
                    w_vy_new = c_max_fall;
                end
                w_apply_vy = 1'b1;
            end
            default: mstate_d = GROUND;
        endcase
        w_y_sum = $signed({2'b00, y_q}) + $signed({w_vy_new[10], w_vy_new});
        if (w_apply_vy) begin
            if (w_y_sum >= c_ground) begin
                y_d      = c_ground[9:0];
                vy_d     = '0;
                mstate_d = GROUND;
            end else if (w_y_sum < 12'sd0) begin
                y_d  = '0;
                vy_d = '0;
            end else begin
                y_d  = w_y_sum[9:0];
                vy_d = w_vy_new;
            end
        end
    end

    // The counter holds the frames remaining in the current kick phase, minus one.
    always_comb begin
        kstate_d = kstate_q;
        kcnt_d   = kcnt_q;
        case (kstate_q)
            K_IDLE: begin
                if (w_kick_edge) begin
                    kstate_d = K_ACTIVE;
                    kcnt_d   = c_kick_load;
                end
            end
            K_ACTIVE: begin
                if (kcnt_q == 8'd0) begin
                    kstate_d = K_COOL;
                    kcnt_d   = c_cool_load;
                end else begin
                    kcnt_d = kcnt_q - 8'd1;
                end
            end
            K_COOL: begin
                if (kcnt_q == 8'd0) begin
                    kstate_d = K_IDLE;
                end else begin
                    kcnt_d = kcnt_q - 8'd1;
                end
            end
            default: begin
                kstate_d = K_IDLE;
                kcnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_q         <= 10'(X_START);
            y_q         <= c_ground[9:0];
            vy_q        <= '0;
            facing_q    <= 1'b1;
            mstate_q    <= GROUND;
            kstate_q    <= K_IDLE;
            kcnt_q      <= '0;
            jump_prev_q <= 1'b0;
            kick_prev_q <= 1'b0;
        end else if (enable) begin
            x_q         <= x_d;
            y_q         <= y_d;
            vy_q        <= vy_d;
            facing_q    <= facing_d;
            mstate_q    <= mstate_d;
            kstate_q    <= kstate_d;
            kcnt_q      <= kcnt_d;
            jump_prev_q <= jump_prev_d;
            kick_prev_q <= kick_prev_d;
        end
    end

    assign CharX    = x_q;
    assign CharY    = y_q;
    assign CharS    = 10'(SIZE);
    assign Facing   = facing_q;
    assign Kicking  = (kstate_q == K_ACTIVE);
    assign Airborne = (mstate_q == AIR);

endmodule

`default_nettype wire

// File: tb/tb_character_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_character_ctrl
// Brief   : Self-checking bench for character_ctrl (vector table + scoreboard).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_character_ctrl;

    logic        frame_clk = 1'b0;
    logic        Reset_n;
    logic        enable;
    logic [31:0] keycode;
    logic [9:0]  CharX, CharY, CharS;
    logic        Facing, Kicking, Airborne;

    always #5 frame_clk = ~frame_clk;

    character_ctrl dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .enable    (enable),
        .keycode   (keycode),
        .CharX     (CharX),
        .CharY     (CharY),
        .CharS     (CharS),
        .Facing    (Facing),
        .Kicking   (Kicking),
        .Airborne  (Airborne)
    );

    typedef struct {
        logic [31:0] kc;
        logic        en;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        f;
        logic        k;
        logic        a;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[9];
    int   checks = 0;
    int   errors = 0;

    // Reference state of the sprite
    int   ex = 200, ey = 368, evy = 0;
    bit   ef = 1'b1, ea = 1'b0, ek = 1'b0, jprev = 1'b0;
    int   ymin;

    function automatic vec_t mk(input logic [31:0] kc, input logic en);
        vec_t v;
        v.kc = kc;
        v.en = en;
        v.x  = 10'(ex);
        v.y  = 10'(ey);
        v.f  = ef;
        v.k  = ek;
        v.a  = ea;
        return v;
    endfunction

    task automatic vmodel(input bit jump_held);
        if (!ea) begin
            if (jump_held && !jprev) begin
                evy = -18;
                ey  = ey - 18;
                ea  = 1'b1;
            end
        end else begin
            evy = evy + 1;
            if (evy > 12) evy = 12;
            ey = ey + evy;
            if (ey >= 368) begin
                ey  = 368;
                evy = 0;
                ea  = 1'b0;
            end else if (ey < 0) begin
                ey  = 0;
                evy = 0;
            end
        end
        jprev = jump_held;
    endtask

    task automatic compare(input string name, input vec_t e);
        checks++;
        if (CharX !== e.x || CharY !== e.y || Facing !== e.f ||
            Kicking !== e.k || Airborne !== e.a) begin
            errors++;
            $display("FAIL %s: got X=%0d Y=%0d F=%b K=%b A=%b, want X=%0d Y=%0d F=%b K=%b A=%b",
                     name, CharX, CharY, Facing, Kicking, Airborne,
                     e.x, e.y, e.f, e.k, e.a);
        end
    endtask

    task automatic step(input string name, input vec_t v);
        keycode = v.kc;
        enable  = v.en;
        sb.push_back(v);
        @(posedge frame_clk);
        #1;
        compare(name, sb.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{32'h0000_0004, 1'b1, 10'd196, 10'd368, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_0004, 1'b1, 10'd192, 10'd368, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{32'h0000_0004, 1'b1, 10'd188, 10'd368, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'h0000_0704, 1'b1, 10'd188, 10'd368, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{32'h0007_0004, 1'b1, 10'd188, 10'd368, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'h0700_0000, 1'b1, 10'd192, 10'd368, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{32'h0000_0000, 1'b1, 10'd192, 10'd368, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{32'h0000_0004, 1'b0, 10'd192, 10'd368, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{32'h0400_0000, 1'b1, 10'd188, 10'd368, 1'b0, 1'b0, 1'b0};

        Reset_n = 1'b1;
        enable  = 1'b1;
        keycode = '0;
        #2 Reset_n = 1'b0;
        #2;
        compare("reset_async", mk(32'h0, 1'b1));
        checks++;
        if (CharS !== 10'd32) begin
            errors++;
            $display("FAIL chars: got %0d want 32", CharS);
        end
        @(negedge frame_clk);
        @(negedge frame_clk);
        Reset_n = 1'b1;

        repeat (5) step("idle_after_reset", mk(32'h0, 1'b1));

        foreach (tbl[i]) step("walk_table", tbl[i]);
        ex = 188;
        ef = 1'b0;

        for (int i = 0; i < 50; i++) begin
            ex = (ex - 4 < 0) ? 0 : ex - 4;
            step("left_clamp", mk(32'h04, 1'b1));
        end
        ef = 1'b1;
        for (int i = 0; i < 155; i++) begin
            ex = (ex + 4 > 607) ? 607 : ex + 4;
            step("right_clamp", mk(32'h07, 1'b1));
        end

        // Jump key held throughout: one arc, then stays grounded.
        ymin = 1000;
        for (int i = 0; i < 60; i++) begin
            vmodel(1'b1);
            step("jump_held", mk(32'h1A, 1'b1));
            if (int'(CharY) < ymin) ymin = int'(CharY);
        end
        checks++;
        if (ymin != 197) begin
            errors++;
            $display("FAIL jump_apex: got %0d want 197", ymin);
        end
        vmodel(1'b0);
        step("jump_release", mk(32'h0, 1'b1));

        // Kick tap, presses during cooldown, then a fresh press once idle.
        for (int i = 0; i < 34; i++) begin
            logic [31:0] kc;
            kc = (i == 0 || i == 17 || (i >= 7 && i <= 15 && (i % 2) == 1)) ? 32'h16 : 32'h0;
            ek = (i <= 5) || (i >= 17 && i <= 22);
            vmodel(1'b0);
            step("kick_seq", mk(kc, 1'b1));
        end

        // Jump and kick together, then freeze mid-air and mid-kick.
        ek = 1'b1;
        vmodel(1'b1);
        step("combo_start", mk(32'h0000_1A16, 1'b1));
        vmodel(1'b1);
        step("combo_hold", mk(32'h0000_1A16, 1'b1));
        repeat (5) step("freeze", mk(32'h0, 1'b0));
        for (int j = 0; j < 3; j++) begin
            vmodel(1'b0);
            step("resume", mk(32'h0, 1'b1));
        end

        // Asynchronous reset pulse between edges while jumping and kicking.
        #2 Reset_n = 1'b0;
        #1;
        ex = 200; ey = 368; evy = 0; ea = 1'b0; ef = 1'b1; ek = 1'b0; jprev = 1'b0;
        compare("reset_midair", mk(32'h0, 1'b1));
        #1 Reset_n = 1'b1;
        repeat (4) step("post_reset", mk(32'h0, 1'b1));
        ek = 1'b1;
        step("kick_after_reset", mk(32'h16, 1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
